// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the single register-file write port.
// Optional WB_ARB_ROUND_ROBIN_EN: same-edge ties alternate instead of favouring the load port.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [AW-1:0]     p0_rd,
  input  logic [WIDTH-1:0]  p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [AW-1:0]     p1_rd,
  input  logic [WIDTH-1:0]  p1_data,
  output logic              p1_ready,
  output logic              write_en,
  output logic [AW-1:0]     rd,
  output logic [WIDTH-1:0]  data,
  output logic [2**AW-1:0]  pending
);

  logic             full0, full1;
  logic [AW-1:0]    brd0, brd1;
  logic [WIDTH-1:0] bdat0, bdat1;
  logic             age_set, age_old;
  logic             grant0, grant1;
  logic             acc0, acc1, load0, load1;
  logic             keep0, keep1;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  logic tie;
  assign tie = full0 && full1 && !age_set && !reset;
`endif

  // Grant selection: oldest full buffer, tie policy when loaded together
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (full0 && full1) begin
        if (age_set) begin
          grant0 = !age_old;
          grant1 = age_old;
        end else begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          grant0 = !rr_ptr;
          grant1 = rr_ptr;
`else
          grant1 = 1'b1;
`endif
        end
      end else begin
        grant0 = full0;
        grant1 = full1;
      end
    end
  end

  assign p0_ready = !full0 || grant0;
  assign p1_ready = !full1 || grant1;

  assign acc0  = p0_valid && p0_ready && !reset;
  assign acc1  = p1_valid && p1_ready && !reset;
  assign load0 = acc0 && (p0_rd != '0);
  assign load1 = acc1 && (p1_rd != '0);
  assign keep0 = full0 && !grant0;
  assign keep1 = full1 && !grant1;

  assign write_en = grant0 || grant1;
  assign rd   = grant0 ? brd0  : (grant1 ? brd1  : '0);
  assign data = grant0 ? bdat0 : (grant1 ? bdat1 : '0);

  // Outstanding destinations; x0 never shows as pending
  always_comb begin
    pending = '0;
    if (full0) pending[brd0] = 1'b1;
    if (full1) pending[brd1] = 1'b1;
    pending[0] = 1'b0;
  end

  // Holding buffers: load on accept, clear when drained
  always_ff @(posedge clk) begin
    if (reset) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      brd0  <= '0;
      brd1  <= '0;
      bdat0 <= '0;
      bdat1 <= '0;
    end else begin
      if (load0) begin
        full0 <= 1'b1;
        brd0  <= p0_rd;
        bdat0 <= p0_data;
      end else if (grant0) begin
        full0 <= 1'b0;
      end
      if (load1) begin
        full1 <= 1'b1;
        brd1  <= p1_rd;
        bdat1 <= p1_data;
      end else if (grant1) begin
        full1 <= 1'b0;
      end
    end
  end

  // Age tracking: the buffer still full when the other loads is older
  always_ff @(posedge clk) begin
    if (reset) begin
      age_set <= 1'b0;
      age_old <= 1'b0;
    end else if (load0 && load1) begin
      age_set <= 1'b0;
    end else if (load0 && keep1) begin
      age_set <= 1'b1;
      age_old <= 1'b1;
    end else if (load1 && keep0) begin
      age_set <= 1'b1;
      age_old <= 1'b0;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Tie pointer flips to the other port after each tie grant
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (tie) begin
      rr_ptr <= !rr_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised self-checking bench for regfile_wb_arbiter.
// Reference model tracks buffer contents with load timestamps.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic [4:0]  p0_rd, p1_rd;
  logic [31:0] p0_data, p1_data;
  logic        p0_ready, p1_ready;
  logic        write_en;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [31:0] pending;

  int nvec = 0;
  int nerr = 0;

  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  int          m_ts   [2];
  int          m_cyc  = 0;
  int          m_fav  = 0;

  regfile_wb_arbiter #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_rd(p0_rd),
    .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_rd(p1_rd),
    .p1_data(p1_data), .p1_ready(p1_ready),
    .write_en(write_en), .rd(rd),
    .data(data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Which port the model drains this cycle, -1 for none
  function automatic int mgrant(input bit rs);
    if (rs) return -1;
    if (m_full[0] && m_full[1]) begin
      if (m_ts[0] < m_ts[1]) return 0;
      if (m_ts[1] < m_ts[0]) return 1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      return m_fav;
`else
      return 1;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 2; i++)
      if (m_full[i]) p[m_rd[i]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic step(input bit rs,
                      input bit v0, input logic [4:0] r0,
                      input logic [31:0] d0,
                      input bit v1, input logic [4:0] r1,
                      input logic [31:0] d1);
    int  g;
    bit  a0, a1, tie;
    reset    = rs;
    p0_valid = v0; p0_rd = r0; p0_data = d0;
    p1_valid = v1; p1_rd = r1; p1_data = d1;
    @(negedge clk);
    g = mgrant(rs);
    check("write_en", 64'(write_en), 64'(g >= 0));
    check("rd", 64'(rd), (g < 0) ? 64'd0 : 64'(m_rd[g]));
    check("data", 64'(data), (g < 0) ? 64'd0 : 64'(m_data[g]));
    check("pending", 64'(pending), 64'(mpend()));
    if (!rs) begin
      check("p0_ready", 64'(p0_ready), 64'(!m_full[0] || g == 0));
      check("p1_ready", 64'(p1_ready), 64'(!m_full[1] || g == 1));
    end
    @(posedge clk);
    if (rs) begin
      m_full[0] = 0; m_full[1] = 0; m_fav = 0;
    end else begin
      tie = m_full[0] && m_full[1] && m_ts[0] == m_ts[1];
      a0 = v0 && (!m_full[0] || g == 0);
      a1 = v1 && (!m_full[1] || g == 1);
      if (tie) m_fav = (g == 0) ? 1 : 0;
      if (g >= 0) m_full[g] = 0;
      if (a0 && r0 != 0) begin
        m_full[0] = 1; m_rd[0] = r0;
        m_data[0] = d0; m_ts[0] = m_cyc;
      end
      if (a1 && r1 != 0) begin
        m_full[1] = 1; m_rd[1] = r1;
        m_data[1] = d1; m_ts[1] = m_cyc;
      end
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    p0_valid = 0; p0_rd = '0; p0_data = '0;
    p1_valid = 0; p1_rd = '0; p1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_we", 64'(write_en), 64'd0);
    check("rst_pend", 64'(pending), 64'd0);
    check("rst_rdy0", 64'(p0_ready), 64'd1);
    check("rst_rdy1", 64'(p1_ready), 64'd1);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_data", 64'(data), 64'd0);

    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    check("w5_en", 64'(write_en), 64'd1);
    check("w5_rd", 64'(rd), 64'd5);
    check("w5_data", 64'(data), 64'hDEADBEEF);
    check("w5_pend", 64'(pending), 64'h20);
    idle();
    check("w5_clr", 64'(pending), 64'd0);

    for (int k = 1; k <= 4; k++) begin
      check("str_rdy", 64'(p0_ready), 64'd1);
      step(0, 1, 5'(k), 32'(k * 3), 0, 5'd0, 32'd0);
      check("str_en", 64'(write_en), 64'd1);
      check("str_rd", 64'(rd), 64'(k));
    end
    idle();
    check("str_end", 64'(write_en), 64'd0);

    for (int t = 0; t < 2; t++) begin
      step(0, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
      check("tie_en1", 64'(write_en), 64'd1);
`ifdef WB_ARB_ROUND_ROBIN_EN
      check("tie_d1", 64'(data), (t == 0) ? 64'h11 : 64'h22);
`else
      check("tie_d1", 64'(data), 64'h22);
`endif
      idle();
      check("tie_en2", 64'(write_en), 64'd1);
`ifdef WB_ARB_ROUND_ROBIN_EN
      check("tie_d2", 64'(data), (t == 0) ? 64'h22 : 64'h11);
`else
      check("tie_d2", 64'(data), 64'h11);
`endif
      idle();
      check("tie_end", 64'(write_en), 64'd0);
    end

    step(0, 1, 5'd6, 32'hA, 1, 5'd9, 32'hB);
    step(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'hC);
    step(0, 1, 5'd9, 32'hD, 0, 5'd0, 32'd0);
    repeat (4) idle();

    step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0);
    check("x0_en", 64'(write_en), 64'd0);
    check("x0_pend", 64'(pending), 64'd0);
    check("x0_rdy", 64'(p0_ready), 64'd1);
    idle();

    step(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    step(1, 1, 5'd8, 32'h88, 1, 5'd10, 32'hAA);
    check("rs_en", 64'(write_en), 64'd0);
    check("rs_pend", 64'(pending), 64'd0);
    check("rs_rdy0", 64'(p0_ready), 64'd1);
    check("rs_rdy1", 64'(p1_ready), 64'd1);
    idle();
    check("rs_en2", 64'(write_en), 64'd0);

    for (int n = 0; n < 2500; n++) begin
      step(($urandom % 60) == 0,
           ($urandom % 3) != 0, 5'($urandom % 6), $urandom,
           ($urandom % 3) != 0, 5'($urandom % 6), $urandom);
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_en/rd/data) between two writeback requesters: port 0 = ALU writeback, port 1 = load/memory writeback.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The arbiter drains at most one buffer per cycle into the register file.
- Also exports a pending-write bitmap so decode can stall on in-flight destinations.

Parameters:
- WIDTH, 32, data width of register-file write data.
- AW, 5, register index width; register count is 2**AW.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- p0_valid  input  1  port 0 write request valid.
- p0_rd  input  AW  port 0 destination register.
- p0_data  input  WIDTH  port 0 write data.
- p0_ready  output  1  port 0 can accept this cycle.
- p1_valid  input  1  port 1 write request valid.
- p1_rd  input  AW  port 1 destination register.
- p1_data  input  WIDTH  port 1 write data.
- p1_ready  output  1  port 1 can accept this cycle.
- write_en  output  1  register-file write enable.
- rd  output  AW  register-file write index.
- data  output  WIDTH  register-file write data.
- pending  output  2**AW  bit r set while a buffered write to r (r≠0) is outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset state:
  - Both buffers empty.
  - Age flag cleared and round-robin pointer = 0.
  - write_en=0, pending=0, p0_ready=p1_ready=1.
  - rd and data read 0 while write_en=0.
- Handshake:
  - Transfer on port i occurs at a rising edge where pi_valid && pi_ready.
  - pi_ready = !full_i || grant_i, so one port can accept back-to-back every cycle.
  - pi_ready must not depend combinationally on pi_valid.
- x0 filtering:
  - An accepted request with rd==0 is consumed but never buffered.
  - It never asserts write_en and never sets pending.
- Latency: a write accepted at edge N appears on write_en/rd/data during the cycle after edge N, at the earliest. The register file commits it at edge N+1.
- Grant (combinational from buffer state, at most one grant per cycle):
  - Neither buffer full: no grant; write_en=0.
  - One buffer full: grant it.
  - Both full, loaded at different edges: grant the older one (age flag). This preserves write order to the same rd.
  - Both full, loaded at the same edge: tie broken by the arbitration policy (see Optional Feature).
- Granted buffer:
  - Drives write_en=1, rd=buf_rd, data=buf_data.
  - Clears at the edge unless refilled by a simultaneous accept on the same port.
- Age flag: updated whenever a buffer loads while the other is still full after that edge; the still-full buffer is recorded as older.
- pending: OR over full buffers of the one-hot decode of buf_rd. Bit 0 is always 0. Combinational from registered state only.
- Starvation bound: a full buffer is granted within 2 cycles under any input pattern.
- Reset mid-operation:
  - Buffered writes are discarded; no write_en in the reset cycle or the cycle after.
  - Handshakes presented during reset are not accepted.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: same-edge ties alternate. The pointer names the favoured port and flips to the other port after each tie grant.
- Undefined: same-edge ties always grant port 1 (load). The pointer is absent.

Test Plan:
- Reset, then p0 write rd=5 data=0xDEADBEEF:
  - Next cycle write_en=1, rd=5, data=0xDEADBEEF.
  - pending[5]=1 for exactly that cycle.
- p0 streams rd=1..4 on consecutive cycles with p1 idle:
  - p0_ready stays 1.
  - write_en asserted 4 consecutive cycles with rd=1,2,3,4.
- p0 and p1 valid same cycle, rd=7/data=0x11 and rd=7/data=0x22:
  - Two writes on consecutive cycles.
  - Order 1→0 without the macro.
  - With the macro, the order alternates across repeated ties.
- p1 accepted rd=9 at edge N, p0 rd=9 at edge N+1, with p1 blocked from draining by a same-edge tie setup:
  - Older p1 write (rd=9) commits first.
  - pending[9] stays 1 until both have committed.
- p0 write rd=0 data=0xFFFFFFFF:
  - p0_ready=1.
  - write_en never asserts.
  - pending stays 0.
- Both buffers full, reset asserted one cycle:
  - Buffers cleared and pending=0 after reset.
  - No write_en issued.
  - Both readies =1.
